// File: rtl/instruction_decoder.sv
// Instruction decoder: latches the 8-bit program word on run and, one cycle later,
// pulses datapath load enables / sequencer jump requests; owns the zero flag (dont_jmp).
module instruction_decoder #(
    parameter int   IMM_W    = 4,
    parameter logic ZF_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       pm_data,
    input  logic             run,
    input  logic             alu_zero,
    output logic [7:0]       reg_en,
    output logic [2:0]       src_sel,
    output logic             imm_sel,
    output logic [IMM_W-1:0] imm,
    output logic [IMM_W-1:0] alu_func,
    output logic             alu_sel,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [IMM_W-1:0] jmp_addr,
    output logic             dont_jmp,
    output logic [7:0]       ir,
    output logic [7:0]       from_ID
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   in_exec;
    logic   is_alu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            if (run) begin
                ir <= pm_data;
            end
        end
    end

    // Every run pulse opens exactly one EXEC cycle, whether or not we are already executing.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = run ? EXEC : IDLE;
            EXEC:    state_next = run ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_exec = (state == EXEC);
    assign is_alu  = (ir[7:5] == 3'b110);

    // The flag only moves when an ALU instruction finishes executing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dont_jmp <= ZF_RESET;
        end else if (in_exec && is_alu) begin
            dont_jmp <= alu_zero;
        end
    end

    always_comb begin
        reg_en  = 8'h00;
        imm_sel = 1'b0;
        jmp     = 1'b0;
        jmp_nz  = 1'b0;
        if (in_exec) begin
            if (!ir[7]) begin
                reg_en  = 8'h01 << ir[6:4];
                imm_sel = 1'b1;
            end else if (!ir[6]) begin
                // mov onto itself is a NOP
                if (ir[5:3] != ir[2:0]) begin
                    reg_en = 8'h01 << ir[5:3];
                end
            end else if (!ir[5]) begin
                reg_en = 8'h80;
            end else if (!ir[4]) begin
                jmp = 1'b1;
            end else begin
                jmp_nz = 1'b1;
            end
        end
    end

    assign imm      = ir[IMM_W-1:0];
    assign alu_func = ir[IMM_W-1:0];
    assign jmp_addr = ir[IMM_W-1:0];
    assign alu_sel  = ir[4];
    assign src_sel  = ir[2:0];

    assign from_ID = {in_exec, 3'b000, dont_jmp, jmp, jmp_nz, |reg_en};

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: a behavioural model predicts each cycle's
// outputs into a queue, a negedge monitor pops and compares.
module tb_instruction_decoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] pm_data;
    logic       run;
    logic       alu_zero;
    logic [7:0] reg_en;
    logic [2:0] src_sel;
    logic       imm_sel;
    logic [3:0] imm;
    logic [3:0] alu_func;
    logic       alu_sel;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] ir;
    logic [7:0] from_ID;

    instruction_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pm_data  (pm_data),
        .run      (run),
        .alu_zero (alu_zero),
        .reg_en   (reg_en),
        .src_sel  (src_sel),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .alu_func (alu_func),
        .alu_sel  (alu_sel),
        .jmp      (jmp),
        .jmp_nz   (jmp_nz),
        .jmp_addr (jmp_addr),
        .dont_jmp (dont_jmp),
        .ir       (ir),
        .from_ID  (from_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] reg_en;
        logic       imm_sel;
        logic       jmp;
        logic       jmp_nz;
        logic [2:0] src_sel;
        logic [3:0] imm;
        logic [3:0] alu_func;
        logic       alu_sel;
        logic [3:0] jmp_addr;
        logic       dont_jmp;
        logic [7:0] ir;
        logic [7:0] from_id;
    } expect_t;

    expect_t exp_q[$];
    int      tests_run = 0;
    int      tests_failed = 0;

    // Model state: what instruction is executing this cycle and the zero flag.
    bit         m_exec;
    logic [7:0] m_ir;
    bit         m_zf;
    bit         prev_run;
    logic [7:0] prev_data;
    bit         prev_az;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic expect_t predict(input bit exec, input logic [7:0] word, input bit zf);
        expect_t e;
        int dst;
        int src;
        e = '0;
        e.ir       = word;
        e.dont_jmp = zf;
        e.imm      = word[3:0];
        e.alu_func = word[3:0];
        e.jmp_addr = word[3:0];
        e.alu_sel  = word[4];
        e.src_sel  = word[2:0];
        if (exec) begin
            if (word < 8'h80) begin
                dst = (word / 16) % 8;
                e.reg_en  = 8'(1 << dst);
                e.imm_sel = 1'b1;
            end else if (word < 8'hC0) begin
                dst = (word / 8) % 8;
                src = word % 8;
                if (dst != src) e.reg_en = 8'(1 << dst);
            end else if (word < 8'hE0) begin
                e.reg_en = 8'h80;
            end else if (word < 8'hF0) begin
                e.jmp = 1'b1;
            end else begin
                e.jmp_nz = 1'b1;
            end
        end
        e.from_id = {exec, 3'b000, zf, e.jmp, e.jmp_nz, (e.reg_en != 0)};
        return e;
    endfunction

    // One clock: advance the model across the edge, queue the expectation, drive new inputs.
    task automatic applyStimulus(input bit r, input logic [7:0] d, input bit az);
        @(posedge clk);
        if (m_exec && (m_ir >= 8'hC0) && (m_ir < 8'hE0)) m_zf = prev_az;
        if (prev_run) begin
            m_ir   = prev_data;
            m_exec = 1'b1;
        end else begin
            m_exec = 1'b0;
        end
        exp_q.push_back(predict(m_exec, m_ir, m_zf));
        #1;
        run       = r;
        pm_data   = d;
        alu_zero  = az;
        prev_run  = r;
        prev_data = d;
        prev_az   = az;
    endtask

    // Reset asserted shortly after an edge, i.e. in the middle of whatever is executing.
    task automatic applyReset(input int cycles);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        run      = 1'b1;
        pm_data  = 8'($urandom);
        alu_zero = 1'($urandom);
        m_exec   = 1'b0;
        m_ir     = 8'h00;
        m_zf     = 1'b1;
        #1;
        checkOutput("reset reg_en", 32'(reg_en), 32'h00);
        checkOutput("reset ir", 32'(ir), 32'h00);
        checkOutput("reset dont_jmp", 32'(dont_jmp), 32'h1);
        checkOutput("reset from_ID", 32'(from_ID), 32'h08);
        exp_q.push_back(predict(1'b0, 8'h00, 1'b1));
        for (int i = 1; i < cycles; i++) begin
            @(posedge clk);
            exp_q.push_back(predict(1'b0, 8'h00, 1'b1));
        end
        #3;
        reset_n   = 1'b1;
        run       = 1'b0;
        pm_data   = 8'h00;
        alu_zero  = 1'b0;
        prev_run  = 1'b0;
        prev_data = 8'h00;
        prev_az   = 1'b0;
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("strobes", {19'b0, reg_en, imm_sel, jmp, jmp_nz, |reg_en, 1'b0},
                            {19'b0, e.reg_en, e.imm_sel, e.jmp, e.jmp_nz, (e.reg_en != 0), 1'b0});
                checkOutput("fields", {16'b0, src_sel, imm, alu_func, alu_sel},
                            {16'b0, e.src_sel, e.imm, e.alu_func, e.alu_sel});
                checkOutput("jmp_addr/dont_jmp/ir", {19'b0, jmp_addr, dont_jmp, ir},
                            {19'b0, e.jmp_addr, e.dont_jmp, e.ir});
                checkOutput("from_ID", 32'(from_ID), 32'(e.from_id));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        reset_n  = 1'b0;
        run      = 1'b0;
        pm_data  = 8'h00;
        alu_zero = 1'b0;
        m_exec = 1'b0; m_ir = 8'h00; m_zf = 1'b1;
        prev_run = 1'b0; prev_data = 8'h00; prev_az = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // load immediate into y1, then idle
        applyStimulus(1'b1, 8'h35, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // unconditional jump
        applyStimulus(1'b1, 8'hE7, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // ALU with zero result, then jnz back-to-back
        applyStimulus(1'b1, 8'hC3, 1'b0);
        applyStimulus(1'b1, 8'hF4, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // ALU with non-zero result clears the flag
        applyStimulus(1'b1, 8'hC3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // mov y1<-y0, then mov onto itself
        applyStimulus(1'b1, 8'h9A, 1'b0);
        applyStimulus(1'b1, 8'h92, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // reset while an immediate load is executing
        applyStimulus(1'b1, 8'h35, 1'b0);
        applyReset(2);
        applyStimulus(1'b0, 8'h00, 1'b0);
        // back-to-back run
        applyStimulus(1'b1, 8'h35, 1'b0);
        applyStimulus(1'b1, 8'hE2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                applyReset(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
